// File: rtl/tdc_sync_pkg.sv
// Shared types for the TDC front-end synchronizer bank: edge selection enum
// and a clog2 helper that never returns a zero width.
package tdc_sync_pkg;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_BOTH = 2'd2
    } edge_mode_e;

    // Index width for n items, at least one bit so single-channel builds stay legal.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Single-bit multi-flop synchronizer with asynchronous active-high reset.
// Bit 0 samples the asynchronous input; q is the last stage.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    // Shift the sampled input one stage per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ff <= '0;
        else     ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/sync_event_bank.sv
// Multi-channel synchronizer, edge detector and event queue for the TDC front end.
// Each channel: sync chain -> optional glitch filter -> edge detect -> pending bit.
// A round-robin arbiter offers one pending channel at a time on a valid/ready slot;
// a qualifying edge that finds its pending bit already set raises sticky overflow.
// Optional feature macro: SYNC_FILTER_EN (glitch filter of FILTER_LEN cycles).
module sync_event_bank
    import tdc_sync_pkg::*;
#(
    parameter int         CHANNELS   = 8,
    parameter int         STAGES     = 2,
    parameter edge_mode_e EDGE_MODE  = EDGE_RISE,
    parameter int         FILTER_LEN = 4,
    localparam int        CW         = clog2_min1(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] async_in,
    input  logic [CHANNELS-1:0] chan_en,
    output logic [CHANNELS-1:0] level_sync,
    output logic [CHANNELS-1:0] edge_pulse,
    output logic                evt_valid,
    output logic [CW-1:0]       evt_chan,
    input  logic                evt_ready,
    output logic [CHANNELS-1:0] overflow,
    input  logic [CHANNELS-1:0] ovf_clr
);

    logic [CHANNELS-1:0] raw;
    logic [CHANNELS-1:0] prev;
    logic [CHANNELS-1:0] pending;
    logic [CHANNELS-1:0] qual;
    logic [CHANNELS-1:0] clr;
    logic [CW-1:0]       ptr;
    logic [CW-1:0]       sel;
    logic [CW-1:0]       idx;
    logic [CW-1:0]       sel_nxt;
    logic                found;
    logic                slot_free;
    logic                take;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        sync_chain #(.STAGES(STAGES)) u_sync (
            .clk (clk),
            .rst (rst),
            .d   (async_in[c]),
            .q   (raw[c])
        );

`ifdef SYNC_FILTER_EN
        localparam int FW = $clog2(FILTER_LEN + 1);
        logic [FW-1:0] cnt;
        logic          lvl;

        // Follow raw only after FILTER_LEN consecutive disagreeing cycles.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt <= '0;
                lvl <= 1'b0;
            end else if (raw[c] == lvl) begin
                cnt <= '0;
            end else if (cnt >= FW'(FILTER_LEN - 1)) begin
                lvl <= raw[c];
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end

        assign level_sync[c] = lvl;
`else
        assign level_sync[c] = raw[c];
`endif
    end

    // Delayed copy of the level for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) prev <= '0;
        else     prev <= level_sync;
    end

    // Edge pulse straight from registers, independent of chan_en.
    always_comb begin
        case (EDGE_MODE)
            EDGE_FALL: edge_pulse = ~level_sync & prev;
            EDGE_BOTH: edge_pulse = level_sync ^ prev;
            default:   edge_pulse = level_sync & ~prev;
        endcase
    end

    assign qual      = edge_pulse & chan_en;
    assign slot_free = ~evt_valid | evt_ready;

    // Round-robin pick: first pending channel at or after ptr, wrapping.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            idx = CW'((int'(ptr) + i) % CHANNELS);
            if (!found && pending[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    assign take    = slot_free & found;
    assign sel_nxt = (sel == CW'(CHANNELS - 1)) ? '0 : sel + 1'b1;

    // One-hot clear of the channel moved into the output slot.
    always_comb begin
        clr = '0;
        if (take) clr[sel] = 1'b1;
    end

    // Pending queue and sticky overflow; an edge on the channel being loaded re-queues cleanly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending  <= '0;
            overflow <= '0;
        end else begin
            pending  <= (pending & ~clr) | qual;
            overflow <= (overflow & ~ovf_clr) | (qual & pending & ~clr);
        end
    end

    // Output slot: reload when empty or consumed, otherwise hold the offered event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_valid <= 1'b0;
            evt_chan  <= '0;
            ptr       <= '0;
        end else if (slot_free) begin
            evt_valid <= found;
            if (found) begin
                evt_chan <= sel;
                ptr      <= sel_nxt;
            end
        end
    end

endmodule

// File: tb/tb_sync_event_bank.sv
// Self-checking bench for sync_event_bank: a vector table for latency and
// arbitration order, directed sequences for overflow, EDGE_BOTH, filter and
// mid-handshake reset, then random stimulus against a behavioural model.
`timescale 1ns/1ps
module tb_sync_event_bank;
    import tdc_sync_pkg::*;

    localparam int N   = 4;
    localparam int ST  = 2;
    localparam int FL  = 4;
    localparam int CWT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst = 1'b1;
    logic [N-1:0]   async_in = '0, chan_en = '1, ovf_clr = '0;
    logic           evt_ready = 1'b0;
    logic [N-1:0]   level_sync, edge_pulse, overflow;
    logic           evt_valid;
    logic [CWT-1:0] evt_chan;

    logic [N-1:0]   b_in = '0, b_en = 4'b1110;
    logic [N-1:0]   b_lvl, b_edge, b_ovf;
    logic           b_valid;
    logic [CWT-1:0] b_chan;

    sync_event_bank #(.CHANNELS(N), .STAGES(ST), .EDGE_MODE(EDGE_RISE), .FILTER_LEN(FL)) dut (
        .clk(clk), .rst(rst), .async_in(async_in), .chan_en(chan_en),
        .level_sync(level_sync), .edge_pulse(edge_pulse), .evt_valid(evt_valid),
        .evt_chan(evt_chan), .evt_ready(evt_ready), .overflow(overflow), .ovf_clr(ovf_clr)
    );

    sync_event_bank #(.CHANNELS(N), .STAGES(ST), .EDGE_MODE(EDGE_BOTH), .FILTER_LEN(FL)) dut_both (
        .clk(clk), .rst(rst), .async_in(b_in), .chan_en(b_en),
        .level_sync(b_lvl), .edge_pulse(b_edge), .evt_valid(b_valid),
        .evt_chan(b_chan), .evt_ready(1'b1), .overflow(b_ovf), .ovf_clr(4'b0000)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: level is the input seen STAGES samples ago (optionally
    // debounced), events queue in a pending set, a slot is served round-robin.
    logic [N-1:0] m_hist [ST];
    logic [N-1:0] m_lvl, m_prev, m_pend, m_ovf;
    logic         m_valid;
    int           m_chan, m_ptr;
    int           m_cnt [N];

    function automatic logic [N-1:0] m_edges();
        return m_lvl & ~m_prev;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < ST; k++) m_hist[k] = '0;
        for (int c = 0; c < N; c++) m_cnt[c] = 0;
        m_lvl = '0; m_prev = '0; m_pend = '0; m_ovf = '0;
        m_valid = 1'b0; m_chan = 0; m_ptr = 0;
    endtask

    task automatic model_step();
        logic [N-1:0] q, clr, raw_old;
        int pick;
        q    = m_edges() & chan_en;
        clr  = '0;
        pick = -1;
        if (!m_valid || evt_ready) begin
            for (int i = 0; i < N; i++)
                if (pick < 0 && m_pend[(m_ptr + i) % N]) pick = (m_ptr + i) % N;
            m_valid = (pick >= 0);
            if (pick >= 0) begin
                clr[pick] = 1'b1;
                m_chan = pick;
                m_ptr  = (pick + 1) % N;
            end
        end
        m_ovf  = (m_ovf & ~ovf_clr) | (q & m_pend & ~clr);
        m_pend = (m_pend & ~clr) | q;
        m_prev = m_lvl;
        raw_old = m_hist[ST-1];
`ifdef SYNC_FILTER_EN
        for (int c = 0; c < N; c++) begin
            if (raw_old[c] == m_lvl[c]) m_cnt[c] = 0;
            else begin
                m_cnt[c]++;
                if (m_cnt[c] >= FL) begin
                    m_lvl[c] = raw_old[c];
                    m_cnt[c] = 0;
                end
            end
        end
`endif
        for (int k = ST - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = async_in;
`ifndef SYNC_FILTER_EN
        m_lvl = m_hist[ST-1];
`endif
    endtask

    // One clock: advance the model at the edge, compare on the falling edge.
    task automatic tick();
        logic [CWT-1:0] mc;
        @(posedge clk);
        if (rst) model_reset();
        else     model_step();
        @(negedge clk);
        mc = CWT'(m_chan);
        chk("model", {level_sync, edge_pulse, overflow, evt_valid, evt_chan},
                     {m_lvl, m_edges(), m_ovf, m_valid, mc});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        async_in = '0; b_in = '0; chan_en = '1; evt_ready = 1'b0; ovf_clr = '0;
        model_reset();
        repeat (2) tick();
        chk("reset_state", {level_sync, edge_pulse, overflow, evt_valid, evt_chan}, '0);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [N-1:0]   ain;
        logic           rdy;
        logic [N-1:0]   e_lvl;
        logic [N-1:0]   e_edge;
        logic           e_v;
        logic [CWT-1:0] e_ch;
    } vec_t;

    vec_t tbl [12];

    initial begin : main
        int cnt, first;
        logic seen;

        tbl[0]  = '{4'hB, 1'b1, 4'h0, 4'h0, 1'b0, 2'd0};
        tbl[1]  = '{4'hB, 1'b1, 4'hB, 4'hB, 1'b0, 2'd0};
        tbl[2]  = '{4'hB, 1'b1, 4'hB, 4'h0, 1'b0, 2'd0};
        tbl[3]  = '{4'hB, 1'b1, 4'hB, 4'h0, 1'b1, 2'd0};
        tbl[4]  = '{4'hB, 1'b1, 4'hB, 4'h0, 1'b1, 2'd1};
        tbl[5]  = '{4'hB, 1'b1, 4'hB, 4'h0, 1'b1, 2'd3};
        tbl[6]  = '{4'hB, 1'b1, 4'hB, 4'h0, 1'b0, 2'd0};
        tbl[7]  = '{4'hF, 1'b1, 4'hB, 4'h0, 1'b0, 2'd0};
        tbl[8]  = '{4'hF, 1'b1, 4'hF, 4'h4, 1'b0, 2'd0};
        tbl[9]  = '{4'hF, 1'b1, 4'hF, 4'h0, 1'b0, 2'd0};
        tbl[10] = '{4'hF, 1'b1, 4'hF, 4'h0, 1'b1, 2'd2};
        tbl[11] = '{4'hF, 1'b1, 4'hF, 4'h0, 1'b0, 2'd0};

        @(negedge clk);
        do_reset();

`ifndef SYNC_FILTER_EN
        // Latency and round-robin order from a fresh pointer.
        for (int i = 0; i < 12; i++) begin
            async_in  = tbl[i].ain;
            evt_ready = tbl[i].rdy;
            tick();
            chk($sformatf("vec%0d_lvl", i), level_sync, tbl[i].e_lvl);
            chk($sformatf("vec%0d_edge", i), edge_pulse, tbl[i].e_edge);
            chk($sformatf("vec%0d_valid", i), evt_valid, tbl[i].e_v);
            if (tbl[i].e_v) chk($sformatf("vec%0d_chan", i), evt_chan, tbl[i].e_ch);
        end
`else
        // Short pulse suppressed; longer pulse appears FL cycles later than the chain alone.
        seen = 1'b0;
        async_in = 4'h1;
        repeat (3) begin tick(); seen |= level_sync[0]; end
        async_in = 4'h0;
        repeat (12) begin tick(); seen |= level_sync[0]; end
        chk("filt_short", seen, 1'b0);
        first = 0;
        async_in = 4'h1;
        for (int t = 1; t <= 14; t++) begin
            if (t == 6) async_in = 4'h0;
            tick();
            if (first == 0 && level_sync[0]) first = t;
        end
        chk("filt_long_latency", first, 6);
`endif

        // Overflow: three edges on channel 1 with the slot stalled.
        do_reset();
        for (int n = 1; n <= 3; n++) begin
            async_in = 4'h2; repeat (5) tick();
            async_in = 4'h0; repeat (5) tick();
            chk($sformatf("ovf_valid%0d", n), evt_valid, 1'b1);
            chk($sformatf("ovf_chan%0d", n), evt_chan, 2'd1);
            chk($sformatf("ovf_flag%0d", n), overflow, (n == 3) ? 4'h2 : 4'h0);
        end
        ovf_clr = 4'h2; tick(); ovf_clr = 4'h0;
        chk("ovf_clear", overflow, 4'h0);
        evt_ready = 1'b1; tick();
        chk("pend_reload_valid", evt_valid, 1'b1);
        chk("pend_reload_chan", evt_chan, 2'd1);
        tick();
        chk("pend_drained", evt_valid, 1'b0);

        // EDGE_BOTH instance with channel 0 disabled.
        do_reset();
        cnt = 0; seen = 1'b0;
        b_in = 4'h1;
        repeat (10) begin tick(); cnt += int'(b_edge[0]); seen |= b_valid; end
        b_in = 4'h0;
        repeat (10) begin tick(); cnt += int'(b_edge[0]); seen |= b_valid; end
        chk("both_pulses", cnt, 2);
        chk("both_no_event", seen, 1'b0);

        // Reset in the middle of a stalled handshake with two more channels pending.
        do_reset();
        async_in = 4'hD;
        repeat (12) tick();
        chk("pre_rst_valid", evt_valid, 1'b1);
        chk("pre_rst_chan", evt_chan, 2'd0);
        #2 rst = 1'b1;
        model_reset();
        #1 chk("async_rst_outputs", {level_sync, edge_pulse, overflow, evt_valid, evt_chan}, '0);
        async_in = '0;
        repeat (2) tick();
        rst = 1'b0;
        seen = 1'b0;
        evt_ready = 1'b1;
        repeat (12) begin tick(); seen |= evt_valid; end
        chk("post_rst_quiet", seen, 1'b0);

        // Random traffic against the model; second half keeps the consumer mostly stalled.
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int c = 0; c < N; c++)
                if ($urandom_range(0, 5) == 0) async_in[c] = ~async_in[c];
            chan_en   = N'($urandom() | $urandom());
            evt_ready = (cyc < 1500) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 7) == 0);
            ovf_clr   = ($urandom_range(0, 15) == 0) ? N'($urandom()) : '0;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sync_event_bank.md
# sync_event_bank

Multi-channel successor to the single-bit synchronizer for the TDC front end. Each of `CHANNELS` asynchronous hit/control inputs passes through a `STAGES`-deep reset-able flop chain, an optional glitch filter and a configurable edge detector. The detected events are queued per channel and handed to the TDC readout logic one at a time. A round-robin arbiter drives a valid/ready handshake that carries the channel index, and per-channel overflow is reported when events are lost.

## Interface
- `CHANNELS`, 8 — number of independent inputs, 1..32
- `STAGES`, 2 — synchronizer flops per channel, ≥2
- `EDGE_MODE`, `EDGE_RISE` — `tdc_sync_pkg::edge_mode_e`: `EDGE_RISE`, `EDGE_FALL`, `EDGE_BOTH`
- `FILTER_LEN`, 4 — consecutive stable cycles for the glitch filter, ≥1; used only with `SYNC_FILTER_EN`
- `CW` — derived, `$clog2(CHANNELS)` (min 1)

Ports:
- `clk` in 1 — sole clock
- `rst` in 1 — reset `rst`, asynchronous, active-high; clock `clk`
- `async_in` in `CHANNELS` — asynchronous inputs
- `chan_en` in `CHANNELS` — per-channel enable; gates event queuing only
- `level_sync` out `CHANNELS` — synchronized (and filtered) level
- `edge_pulse` out `CHANNELS` — one-cycle pulse per detected edge; not gated by `chan_en`
- `evt_valid` out 1 — event offered
- `evt_chan` out `CW` — channel index of the offered event
- `evt_ready` in 1 — consumer accepts
- `overflow` out `CHANNELS` — sticky lost-event flag
- `ovf_clr` in `CHANNELS` — clears the matching `overflow` bits

## Operation
- Reset: all sync flops, filter state, `level_sync`, `edge_pulse`, pending bits, `evt_valid`, `evt_chan`, `overflow` go to 0. The round-robin pointer resets to channel 0.
- Sync chain: bit 0 samples `async_in`; each stage shifts by one per cycle; `level_sync` takes the last stage.
- Edge detect: compare `level_sync` with its one-cycle-delayed copy (`prev`). Rise = `level_sync & ~prev`; fall = `~level_sync & prev`; `EDGE_BOTH` = XOR. `edge_pulse` is combinational from these registers.
- Queue: `pending[c]` sets the cycle after `edge_pulse[c]` when `chan_en[c]`=1.
- Overflow: if `pending[c]` is already 1 when a new qualifying edge arrives, `overflow[c]` sets and `pending[c]` stays 1.
- `ovf_clr[c]` clears `overflow[c]`; a same-cycle set wins over the clear.
- Output slot is loaded when `evt_valid`=0 or `evt_valid & evt_ready`.
  - Load picks the lowest pending channel at or after the pointer, with wrap-around.
  - On load: clear that pending bit, set `evt_chan`, set `evt_valid`, and move the pointer to chan+1 mod `CHANNELS`.
  - If nothing is pending, `evt_valid` goes to 0.
- So one event per channel can sit in the slot and one more in `pending`. A third event on that channel sets `overflow`.
- Handshake: while `evt_valid`=1 and `evt_ready`=0, `evt_valid` and `evt_chan` hold stable. Neither `chan_en` nor a new edge changes the offered event.
- An edge on channel c in the same cycle c is loaded into the slot sets `pending[c]` with no overflow.

## Timing
- With the filter out: `async_in` change sampled at edge 0 → `level_sync` and `edge_pulse` after `STAGES` cycles → `pending` at +1 → `evt_valid` at +2 if the slot is free.
- The filter adds `FILTER_LEN` cycles to `level_sync` and `edge_pulse`.
- Back-to-back throughput is 1 event/cycle with `evt_ready` held high.
- Inputs high at reset release produce a rising edge `STAGES` cycles after `rst` deasserts.
- `rst` asserted mid-handshake drops `evt_valid` immediately and discards all queued events.

## Configuration
- `SYNC_FILTER_EN` defined: per-channel glitch filter between sync chain and edge detector.
  - A saturating counter of `$clog2(FILTER_LEN+1)` bits tracks how long the raw synchronized bit has differed from `level_sync`.
  - `level_sync` flips only after `FILTER_LEN` consecutive differing cycles; the counter resets to 0 on any agreeing cycle.
  - Pulses shorter than `FILTER_LEN` cycles are suppressed.
- Undefined: no filter logic; `level_sync` is the last sync stage; `FILTER_LEN` is ignored.

## Structure
- `tdc_sync_pkg`: `edge_mode_e` enum and a `clog2_min1` constant function.
- Sub-module `sync_chain`: single-bit, `STAGES`-deep async-reset synchronizer, instantiated `CHANNELS` times via generate.
- Filter, edge detect, pending, arbiter and overflow logic live in `sync_event_bank`.

## Test plan
- `CHANNELS`=4, `STAGES`=2, rise mode, filter out: `async_in[2]` 0→1 → `edge_pulse[2]` exactly 2 cycles later for 1 cycle; `evt_valid`=1 with `evt_chan`=2 two cycles after that.
- Channels 0, 1, 3 rise in the same cycle, `evt_ready`=1 → `evt_chan` sequence 0, 1, 3 on consecutive cycles, then `evt_valid`=0.
- `evt_ready`=0; three rising edges on channel 1, 10 cycles apart → slot holds chan 1, `pending[1]`=1, `overflow[1]`=1 after the third edge; `ovf_clr[1]` pulse → `overflow[1]`=0.
- `EDGE_BOTH`, `chan_en[0]`=0: toggle channel 0 → `edge_pulse[0]` on both edges, `evt_valid` never asserted.
- `SYNC_FILTER_EN`, `FILTER_LEN`=4: 3-cycle high pulse → no `level_sync` change; 5-cycle pulse → `level_sync` rises 6 cycles after input.
- `rst` pulsed while `evt_valid`=1 and two channels pending → all outputs 0 asynchronously; no events after release unless inputs change.
